// File: rtl/dmem_arbiter_if.sv
// Bundle of core-port, loader-port and memory-side signals for the data memory arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int AW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wd;
  logic [2:0]    c_ctl;
  logic          c_gnt;
  logic          c_stall;
  logic          c_rvalid;
  logic [31:0]   c_rdata;
  logic          c_err;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wd;
  logic [2:0]    l_ctl;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;

  logic          m_en;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-3:0] m_addr;
  logic [31:0]   m_wd;
  logic [31:0]   m_rd;

  modport slave (
    input  c_req, c_we, c_addr, c_wd, c_ctl,
    input  l_req, l_we, l_addr, l_wd, l_ctl,
    input  m_rd,
    output c_gnt, c_stall, c_rvalid, c_rdata, c_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output m_en, m_we, m_be, m_addr, m_wd
  );

  modport master (
    output c_req, c_we, c_addr, c_wd, c_ctl,
    output l_req, l_we, l_addr, l_wd, l_ctl,
    output m_rd,
    input  c_gnt, c_stall, c_rvalid, c_rdata, c_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  m_en, m_we, m_be, m_addr, m_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core MEM stage and the loader.
// It issues a combinational grant, lane/alignment decode, and a one-cycle registered load response.
module dmem_arbiter #(
  parameter int AW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk_i,
  input logic          rst_ni,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // Returns {err, be} for a funct3/we/offset combination.
  function automatic logic [4:0] lane_decode(input logic [2:0] ctl, input logic we,
                                             input logic [1:0] off);
    logic       err;
    logic [3:0] be;
    case (ctl)
      3'b000, 3'b100: begin
        be  = 4'b0001 << off;
        err = ctl[2] & we;
      end
      3'b001, 3'b101: begin
        be  = off[1] ? 4'b1100 : 4'b0011;
        err = off[0] | (ctl[2] & we);
      end
      3'b010: begin
        be  = 4'b1111;
        err = (off != 2'b00);
      end
      default: begin
        be  = 4'b0000;
        err = 1'b1;
      end
    endcase
    return {err, be};
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] ctl, input logic [31:0] wd);
    logic [31:0] res;
    case (ctl[1:0])
      2'b00:   res = {4{wd[7:0]}};
      2'b01:   res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] ctl, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rd >> {off, 3'b000};
    case (ctl)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b100:  res = {24'h000000, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      3'b010:  res = rd;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  logic [SW-1:0] starve_q, starve_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_port_q, rsp_port_d;
  logic          rsp_we_q, rsp_we_d;
  logic [1:0]    rsp_off_q, rsp_off_d;
  logic [2:0]    rsp_ctl_q, rsp_ctl_d;
  logic          rsp_err_q, rsp_err_d;

  logic          l_win_s, c_gnt_s, l_gnt_s, any_gnt_s, acc_s;
  logic          we_s, err_s;
  logic [AW-1:0] addr_s;
  logic [31:0]   wd_s, rsp_data_s;
  logic [2:0]    ctl_s;
  logic [3:0]    be_s;

  // Arbitration and request mux; grants are forced low while reset is asserted.
  always_comb begin
    l_win_s   = bus.l_req & (~bus.c_req | (starve_q == LIMIT));
    c_gnt_s   = rst_ni & bus.c_req & ~l_win_s;
    l_gnt_s   = rst_ni & l_win_s;
    any_gnt_s = c_gnt_s | l_gnt_s;
    if (l_gnt_s) begin
      we_s   = bus.l_we;
      addr_s = bus.l_addr;
      wd_s   = bus.l_wd;
      ctl_s  = bus.l_ctl;
    end else begin
      we_s   = bus.c_we;
      addr_s = bus.c_addr;
      wd_s   = bus.c_wd;
      ctl_s  = bus.c_ctl;
    end
    {err_s, be_s} = lane_decode(ctl_s, we_s, addr_s[1:0]);
    acc_s         = any_gnt_s & ~err_s;
  end

  // Next state for the starvation counter and the response stage.
  always_comb begin
    if (!bus.l_req || l_gnt_s) begin
      starve_d = '0;
    end else if (c_gnt_s && (starve_q != LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
    rsp_valid_d = any_gnt_s;
    rsp_port_d  = l_gnt_s;
    rsp_we_d    = we_s;
    rsp_off_d   = addr_s[1:0];
    rsp_ctl_d   = ctl_s;
    rsp_err_d   = err_s;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_off_q   <= 2'b00;
      rsp_ctl_q   <= 3'b000;
      rsp_err_q   <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      rsp_we_q    <= rsp_we_d;
      rsp_off_q   <= rsp_off_d;
      rsp_ctl_q   <= rsp_ctl_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_data_s = (rsp_valid_q & ~rsp_we_q & ~rsp_err_q)
                      ? load_extend(rsp_ctl_q, rsp_off_q, bus.m_rd) : 32'h0000_0000;

  assign bus.c_gnt    = c_gnt_s;
  assign bus.l_gnt    = l_gnt_s;
  assign bus.c_stall  = rst_ni & bus.c_req & ~c_gnt_s;
  assign bus.m_en     = acc_s;
  assign bus.m_we     = acc_s & we_s;
  assign bus.m_be     = acc_s ? be_s : 4'b0000;
  assign bus.m_addr   = rst_ni ? addr_s[AW-1:2] : '0;
  assign bus.m_wd     = rst_ni ? lane_data(ctl_s, wd_s) : 32'h0000_0000;

  assign bus.c_rvalid = rsp_valid_q & ~rsp_port_q;
  assign bus.l_rvalid = rsp_valid_q & rsp_port_q;
  assign bus.c_err    = rsp_valid_q & ~rsp_port_q & rsp_err_q;
  assign bus.l_err    = rsp_valid_q & rsp_port_q & rsp_err_q;
  assign bus.c_rdata  = rsp_port_q ? 32'h0000_0000 : rsp_data_s;
  assign bus.l_rdata  = rsp_port_q ? rsp_data_s : 32'h0000_0000;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: access round trips, lane and extension cases,
// error handling, starvation pattern and async reset, with a behavioural memory.
module tb_dmem_arbiter;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  dmem_arbiter_if #(.AW(8)) bus ();

  dmem_arbiter #(.AW(8), .STARVE_LIMIT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.m_be[b]) mem[bus.m_addr][b*8 +: 8] <= bus.m_wd[b*8 +: 8];
        end
      end
      bus.m_rd <= mem[bus.m_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated access on port lp, then its response one cycle later.
  task automatic acc(input bit lp, input bit we, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [2:0] ctl, input logic [3:0] ebe, input logic [31:0] ewd,
                     input bit eerr, input logic [31:0] erd, input string tag);
    logic [5:0] waddr;
    waddr = addr[7:2];
    bus.c_req = ~lp; bus.l_req = lp;
    if (lp) begin
      bus.l_we = we; bus.l_addr = addr; bus.l_wd = wd; bus.l_ctl = ctl;
    end else begin
      bus.c_we = we; bus.c_addr = addr; bus.c_wd = wd; bus.c_ctl = ctl;
    end
    #1;
    chk({tag, ".gnt"}, 32'(lp ? bus.l_gnt : bus.c_gnt), 32'd1);
    chk({tag, ".ognt"}, 32'(lp ? bus.c_gnt : bus.l_gnt), 32'd0);
    chk({tag, ".stall"}, 32'(bus.c_stall), 32'd0);
    chk({tag, ".m_en"}, 32'(bus.m_en), 32'(!eerr));
    chk({tag, ".m_we"}, 32'(bus.m_we), 32'(we && !eerr));
    chk({tag, ".m_be"}, 32'(bus.m_be), eerr ? 32'd0 : 32'(ebe));
    if (!eerr) chk({tag, ".m_addr"}, 32'(bus.m_addr), 32'(waddr));
    if (!eerr && we) chk({tag, ".m_wd"}, bus.m_wd, ewd);
    @(posedge clk);
    #1;
    bus.c_req = 1'b0; bus.l_req = 1'b0;
    chk({tag, ".rvalid"}, 32'(lp ? bus.l_rvalid : bus.c_rvalid), 32'd1);
    chk({tag, ".orvalid"}, 32'(lp ? bus.c_rvalid : bus.l_rvalid), 32'd0);
    chk({tag, ".err"}, 32'(lp ? bus.l_err : bus.c_err), 32'(eerr));
    chk({tag, ".rdata"}, lp ? bus.l_rdata : bus.c_rdata, erd);
    chk({tag, ".ordata"}, lp ? bus.c_rdata : bus.l_rdata, 32'd0);
  endtask

  bit pc, pl, exp_l;

  initial begin
    rst_n = 1'b0;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h10; bus.c_wd = 32'h0; bus.c_ctl = 3'b010;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'h20; bus.l_wd = 32'h0; bus.l_ctl = 3'b010;
    #2;
    chk("rst.c_gnt", 32'(bus.c_gnt), 32'd0);
    chk("rst.l_gnt", 32'(bus.l_gnt), 32'd0);
    chk("rst.c_stall", 32'(bus.c_stall), 32'd0);
    chk("rst.m_en", 32'(bus.m_en), 32'd0);
    chk("rst.m_be", 32'(bus.m_be), 32'd0);
    chk("rst.c_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("rst.l_rvalid", 32'(bus.l_rvalid), 32'd0);
    chk("rst.c_rdata", bus.c_rdata, 32'd0);
    bus.c_req = 1'b0; bus.l_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    acc(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 3'b010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, "c_sw");
    acc(1'b0, 1'b0, 8'h10, 32'h0,        3'b010, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, "c_lw");
    acc(1'b1, 1'b1, 8'h20, 32'h80FF7F01, 3'b010, 4'hF, 32'h80FF7F01, 1'b0, 32'h0, "l_sw");
    acc(1'b0, 1'b0, 8'h23, 32'h0, 3'b000, 4'h8, 32'h0, 1'b0, 32'hFFFFFF80, "lb");
    acc(1'b0, 1'b0, 8'h23, 32'h0, 3'b100, 4'h8, 32'h0, 1'b0, 32'h00000080, "lbu");
    acc(1'b1, 1'b0, 8'h22, 32'h0, 3'b001, 4'hC, 32'h0, 1'b0, 32'hFFFF80FF, "lh");
    acc(1'b0, 1'b0, 8'h20, 32'h0, 3'b101, 4'h3, 32'h0, 1'b0, 32'h00007F01, "lhu");
    acc(1'b0, 1'b1, 8'h21, 32'h000000AB, 3'b000, 4'h2, 32'hABABABAB, 1'b0, 32'h0, "sb");
    acc(1'b1, 1'b1, 8'h22, 32'h00001234, 3'b001, 4'hC, 32'h12341234, 1'b0, 32'h0, "sh");
    acc(1'b0, 1'b1, 8'h23, 32'h00005555, 3'b001, 4'h0, 32'h0, 1'b1, 32'h0, "sh_mis");
    acc(1'b1, 1'b1, 8'h12, 32'h11111111, 3'b010, 4'h0, 32'h0, 1'b1, 32'h0, "sw_mis");
    acc(1'b0, 1'b1, 8'h20, 32'h22222222, 3'b111, 4'h0, 32'h0, 1'b1, 32'h0, "ctl111");
    acc(1'b0, 1'b1, 8'h20, 32'h33333333, 3'b100, 4'h0, 32'h0, 1'b1, 32'h0, "st_bu");
    acc(1'b1, 1'b0, 8'h21, 32'h0, 3'b101, 4'h0, 32'h0, 1'b1, 32'h0, "lhu_mis");
    acc(1'b0, 1'b0, 8'h20, 32'h0, 3'b010, 4'hF, 32'h0, 1'b0, 32'h1234AB01, "rb20");
    acc(1'b1, 1'b0, 8'h10, 32'h0, 3'b010, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, "rb10");

    bus.c_we = 1'b0; bus.c_addr = 8'h10; bus.c_ctl = 3'b010;
    bus.l_we = 1'b0; bus.l_addr = 8'h20; bus.l_ctl = 3'b010;
    #1;
    chk("idle.m_en", 32'(bus.m_en), 32'd0);
    chk("idle.m_we", 32'(bus.m_we), 32'd0);
    chk("idle.m_be", 32'(bus.m_be), 32'd0);
    chk("idle.m_addr", 32'(bus.m_addr), 32'h04);
    @(posedge clk); #1;

    // Both ports held: four core grants, then one loader grant, repeating.
    bus.c_req = 1'b1; bus.l_req = 1'b1;
    pc = 1'b0; pl = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      exp_l = (i % 5 == 0);
      chk("starve.l_gnt", 32'(bus.l_gnt), 32'(exp_l));
      chk("starve.c_gnt", 32'(bus.c_gnt), 32'(!exp_l));
      chk("starve.c_stall", 32'(bus.c_stall), 32'(exp_l));
      if (i > 1) begin
        chk("starve.c_rvalid", 32'(bus.c_rvalid), 32'(pc));
        chk("starve.l_rvalid", 32'(bus.l_rvalid), 32'(pl));
        chk("starve.c_rdata", bus.c_rdata, pc ? 32'hDEADBEEF : 32'h0);
        chk("starve.l_rdata", bus.l_rdata, pl ? 32'h1234AB01 : 32'h0);
      end
      pc = !exp_l; pl = exp_l;
      @(posedge clk);
    end

    // Build up two starvation counts, then reset during a core grant.
    @(posedge clk); @(posedge clk);
    #1;
    chk("prerst.c_gnt", 32'(bus.c_gnt), 32'd1);
    chk("prerst.c_rvalid", 32'(bus.c_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.c_gnt", 32'(bus.c_gnt), 32'd0);
    chk("arst.l_gnt", 32'(bus.l_gnt), 32'd0);
    chk("arst.c_stall", 32'(bus.c_stall), 32'd0);
    chk("arst.m_en", 32'(bus.m_en), 32'd0);
    chk("arst.m_addr", 32'(bus.m_addr), 32'd0);
    chk("arst.m_wd", bus.m_wd, 32'd0);
    chk("arst.c_rvalid", 32'(bus.c_rvalid), 32'd0);
    chk("arst.c_rdata", bus.c_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      #1;
      if (j == 1) chk("postrst.c_rvalid", 32'(bus.c_rvalid), 32'd0);
      chk("postrst.l_gnt", 32'(bus.l_gnt), 32'(j == 5));
      chk("postrst.c_gnt", 32'(bus.c_gnt), 32'(j != 5));
      @(posedge clk);
    end
    #1;
    bus.c_req = 1'b0; bus.l_req = 1'b0;
    chk("postrst.l_rvalid", 32'(bus.l_rvalid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
